// File: rtl/clash_pkg.sv
// Shared troop/damage types and arrow slot state for the tower combat blocks.
package clash_pkg;

  localparam int unsigned TROOP_W  = 3;
  localparam int unsigned DAMAGE_W = 4;
  localparam int unsigned STATS_W  = 16;

  typedef logic [TROOP_W-1:0]  troop_idx_t;
  typedef logic [DAMAGE_W-1:0] damage_t;

  localparam troop_idx_t TROOP_NONE = 3'd0;

  typedef enum logic [1:0] {
    AS_IDLE = 2'd0,
    AS_FLY  = 2'd1,
    AS_HIT  = 2'd2
  } arrow_state_t;

  // Payload carried by an arrow from launch to impact.
  typedef struct packed {
    troop_idx_t target;
    damage_t    damage;
  } hit_evt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;
  logic           found;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    gnt_rot = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_rot[i] && !found) begin
        gnt_rot[i] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt_dbl = {{N{1'b0}}, gnt_rot} << ptr;
    gnt     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
  end

endmodule

// File: rtl/arrow_scheduler.sv
// Shares arrow slots among towers, times flights in frame ticks and serializes hit events.
// Optional ARROW_SCHED_STATS_EN adds a saturating shots_fired counter output.
module arrow_scheduler
  import clash_pkg::*;
#(
  parameter int unsigned NUM_TOWERS = 4,
  parameter int unsigned NUM_ARROWS = 2,
  parameter int unsigned FLIGHT_W   = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic [NUM_TOWERS-1:0]          tower_alive,
  input  logic [NUM_TOWERS-1:0]          fire_req,
  input  logic [NUM_TOWERS*TROOP_W-1:0]  fire_target,
  input  logic [NUM_TOWERS*FLIGHT_W-1:0] fire_ticks,
  input  logic [NUM_TOWERS*DAMAGE_W-1:0] fire_damage,
  output logic [NUM_TOWERS-1:0]          fire_ack,
  output logic [NUM_ARROWS-1:0]          slot_busy,
  output logic [NUM_ARROWS*TROOP_W-1:0]  slot_target,
  output logic                           hit_valid,
  output logic [TROOP_W-1:0]             hit_target,
  output logic [DAMAGE_W-1:0]            hit_damage
`ifdef ARROW_SCHED_STATS_EN
  ,
  output logic [STATS_W-1:0]             shots_fired
`endif
);

  localparam int unsigned PTR_W = (NUM_TOWERS > 1) ? $clog2(NUM_TOWERS) : 1;

  arrow_state_t          state_q [NUM_ARROWS];
  arrow_state_t          state_d [NUM_ARROWS];
  logic [FLIGHT_W-1:0]   cnt_q   [NUM_ARROWS];
  logic [FLIGHT_W-1:0]   cnt_d   [NUM_ARROWS];
  hit_evt_t              evt_q   [NUM_ARROWS];
  hit_evt_t              evt_d   [NUM_ARROWS];

  logic [NUM_TOWERS-1:0] fire_ack_q, fire_ack_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  hit_valid_q, hit_valid_d;
  hit_evt_t              hit_q, hit_d;

  logic [NUM_TOWERS-1:0] elig_c;
  logic [NUM_TOWERS-1:0] gnt_c;
  logic                  free_c;
  hit_evt_t              ld_evt_c;
  logic [FLIGHT_W-1:0]   ld_cnt_c;

  // A tower acked this cycle is still holding its old request; skip it.
  always_comb begin
    for (int unsigned t = 0; t < NUM_TOWERS; t++) begin
      elig_c[t] = fire_req[t] & tower_alive[t] & ~fire_ack_q[t] &
                  (fire_target[t*TROOP_W +: TROOP_W] != TROOP_NONE);
    end
  end

  always_comb begin
    free_c = 1'b0;
    for (int unsigned s = 0; s < NUM_ARROWS; s++) begin
      if (state_q[s] == AS_IDLE) free_c = 1'b1;
    end
  end

  rr_arbiter #(
    .N     (NUM_TOWERS),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (elig_c),
    .ptr (ptr_q),
    .gnt (gnt_c)
  );

  // Payload of the winning tower; a zero flight time is stretched to one tick.
  always_comb begin
    ld_evt_c = '0;
    ld_cnt_c = '0;
    for (int unsigned t = 0; t < NUM_TOWERS; t++) begin
      if (gnt_c[t]) begin
        ld_evt_c.target = fire_target[t*TROOP_W +: TROOP_W];
        ld_evt_c.damage = fire_damage[t*DAMAGE_W +: DAMAGE_W];
        ld_cnt_c        = fire_ticks[t*FLIGHT_W +: FLIGHT_W];
      end
    end
    if (ld_cnt_c == '0) ld_cnt_c = FLIGHT_W'(1);
  end

  // Slot FSMs, hit serialization and grant; the three touch disjoint slot states.
  always_comb begin
    logic hit_taken;
    logic slot_taken;
    state_d     = state_q;
    cnt_d       = cnt_q;
    evt_d       = evt_q;
    fire_ack_d  = '0;
    ptr_d       = ptr_q;
    hit_valid_d = 1'b0;
    hit_d       = '0;
    hit_taken   = 1'b0;
    slot_taken  = 1'b0;

    for (int unsigned s = 0; s < NUM_ARROWS; s++) begin
      case (state_q[s])
        AS_FLY: begin
          if (frame_tick) begin
            if (cnt_q[s] == FLIGHT_W'(1)) state_d[s] = AS_HIT;
            else                          cnt_d[s]   = cnt_q[s] - FLIGHT_W'(1);
          end
        end
        AS_HIT: begin
          if (!hit_taken) begin
            hit_taken   = 1'b1;
            hit_valid_d = 1'b1;
            hit_d       = evt_q[s];
            state_d[s]  = AS_IDLE;
          end
        end
        default: begin
          if (!slot_taken && (gnt_c != '0)) begin
            slot_taken = 1'b1;
            state_d[s] = AS_FLY;
            cnt_d[s]   = ld_cnt_c;
            evt_d[s]   = ld_evt_c;
          end
        end
      endcase
    end

    if (free_c) begin
      fire_ack_d = gnt_c;
      for (int unsigned t = 0; t < NUM_TOWERS; t++) begin
        if (gnt_c[t]) ptr_d = PTR_W'((t + 1) % NUM_TOWERS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_ARROWS; s++) begin
        state_q[s] <= AS_IDLE;
        cnt_q[s]   <= '0;
        evt_q[s]   <= '0;
      end
      fire_ack_q  <= '0;
      ptr_q       <= '0;
      hit_valid_q <= 1'b0;
      hit_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      evt_q       <= evt_d;
      fire_ack_q  <= fire_ack_d;
      ptr_q       <= ptr_d;
      hit_valid_q <= hit_valid_d;
      hit_q       <= hit_d;
    end
  end

`ifdef ARROW_SCHED_STATS_EN
  logic [STATS_W-1:0] shots_q, shots_d;

  always_comb begin
    shots_d = shots_q;
    if ((fire_ack_d != '0) && (shots_q != {STATS_W{1'b1}})) shots_d = shots_q + STATS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) shots_q <= '0;
    else       shots_q <= shots_d;
  end

  assign shots_fired = shots_q;
`endif

  always_comb begin
    for (int unsigned s = 0; s < NUM_ARROWS; s++) begin
      slot_busy[s]                         = (state_q[s] != AS_IDLE);
      slot_target[s*TROOP_W +: TROOP_W]    = evt_q[s].target;
    end
  end

  assign fire_ack   = fire_ack_q;
  assign hit_valid  = hit_valid_q;
  assign hit_target = hit_q.target;
  assign hit_damage = hit_q.damage;

endmodule

// File: tb/tb_arrow_scheduler.sv
// Random + directed bench for arrow_scheduler against an arrow-table reference model.
module tb_arrow_scheduler;

  localparam int NT = 4;
  localparam int NA = 2;
  localparam int FW = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_tick;
  logic [NT-1:0]  tower_alive;
  logic [NT-1:0]  fire_req;
  logic [NT*3-1:0]  fire_target;
  logic [NT*FW-1:0] fire_ticks;
  logic [NT*4-1:0]  fire_damage;
  logic [NT-1:0]  fire_ack;
  logic [NA-1:0]  slot_busy;
  logic [NA*3-1:0] slot_target;
  logic           hit_valid;
  logic [2:0]     hit_target;
  logic [3:0]     hit_damage;
`ifdef ARROW_SCHED_STATS_EN
  logic [15:0]    shots_fired;
`endif

  arrow_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .tower_alive (tower_alive),
    .fire_req    (fire_req),
    .fire_target (fire_target),
    .fire_ticks  (fire_ticks),
    .fire_damage (fire_damage),
    .fire_ack    (fire_ack),
    .slot_busy   (slot_busy),
    .slot_target (slot_target),
    .hit_valid   (hit_valid),
    .hit_target  (hit_target),
    .hit_damage  (hit_damage)
`ifdef ARROW_SCHED_STATS_EN
    ,
    .shots_fired (shots_fired)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Arrow table: 0 = empty, 1 = airborne, 2 = landed and waiting to be reported.
  int         m_st  [NA];
  int         m_rem [NA];
  int         m_tgt [NA];
  int         m_dmg [NA];
  int         m_ptr;
  logic [NT-1:0] m_ack;
  int         m_hv, m_ht, m_hd;
  int         m_shots;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tgt_of(input int i);
    logic [2:0] v;
    v = fire_target[i*3 +: 3];
    return int'(v);
  endfunction

  function automatic int ticks_of(input int i);
    logic [FW-1:0] v;
    v = fire_ticks[i*FW +: FW];
    return int'(v);
  endfunction

  function automatic int dmg_of(input int i);
    logic [3:0] v;
    v = fire_damage[i*4 +: 4];
    return int'(v);
  endfunction

  // What the outputs must be after the coming edge, given current inputs.
  task automatic model_step();
    int cur [NA];
    int free_s;
    logic [NT-1:0] ack_now;
    if (reset) begin
      for (int s = 0; s < NA; s++) begin
        m_st[s] = 0; m_rem[s] = 0; m_tgt[s] = 0; m_dmg[s] = 0;
      end
      m_ptr = 0; m_ack = '0; m_hv = 0; m_ht = 0; m_hd = 0; m_shots = 0;
      return;
    end
    cur = m_st;
    ack_now = m_ack;
    for (int s = 0; s < NA; s++) begin
      if (cur[s] == 1 && frame_tick) begin
        if (m_rem[s] == 1) m_st[s] = 2;
        else m_rem[s] = m_rem[s] - 1;
      end
    end
    m_hv = 0; m_ht = 0; m_hd = 0;
    for (int s = 0; s < NA; s++) begin
      if (cur[s] == 2) begin
        m_hv = 1; m_ht = m_tgt[s]; m_hd = m_dmg[s]; m_st[s] = 0;
        break;
      end
    end
    m_ack = '0;
    free_s = -1;
    for (int s = 0; s < NA; s++) begin
      if (cur[s] == 0) begin
        free_s = s;
        break;
      end
    end
    if (free_s >= 0) begin
      for (int k = 0; k < NT; k++) begin
        int i;
        i = (m_ptr + k) % NT;
        if (fire_req[i] && tower_alive[i] && !ack_now[i] && tgt_of(i) != 0) begin
          m_st[free_s]  = 1;
          m_rem[free_s] = (ticks_of(i) == 0) ? 1 : ticks_of(i);
          m_tgt[free_s] = tgt_of(i);
          m_dmg[free_s] = dmg_of(i);
          m_ack[i]      = 1'b1;
          m_ptr         = (i + 1) % NT;
          if (m_shots < 65535) m_shots++;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NA-1:0] eb;
    for (int s = 0; s < NA; s++) eb[s] = (m_st[s] != 0);
    chk("fire_ack", 32'(fire_ack), 32'(m_ack));
    chk("slot_busy", 32'(slot_busy), 32'(eb));
    for (int s = 0; s < NA; s++) begin
      logic [2:0] st;
      st = slot_target[s*3 +: 3];
      if (eb[s]) chk("slot_target", 32'(st), 32'(m_tgt[s]));
    end
    chk("hit_valid", 32'(hit_valid), 32'(m_hv));
    if (m_hv != 0) begin
      chk("hit_target", 32'(hit_target), 32'(m_ht));
      chk("hit_damage", 32'(hit_damage), 32'(m_hd));
    end
`ifdef ARROW_SCHED_STATS_EN
    chk("shots_fired", 32'(shots_fired), 32'(m_shots));
`endif
  endtask

  // One clock: predict, take the edge, settle, drop acked requests, compare.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    fire_req = fire_req & ~m_ack;
    check_outputs();
  endtask

  task automatic set_tower(input int i, input int tgt, input int tk, input int dmg);
    fire_target[i*3 +: 3]   = 3'(tgt);
    fire_ticks[i*FW +: FW]  = FW'(tk);
    fire_damage[i*4 +: 4]   = 4'(dmg);
    fire_req[i]             = 1'b1;
  endtask

  task automatic do_reset();
    fire_req   = '0;
    frame_tick = 1'b0;
    reset      = 1'b1;
    step();
    reset      = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    frame_tick  = 1'b0;
    tower_alive = '1;
    fire_req    = '0;
    fire_target = '0;
    fire_ticks  = '0;
    fire_damage = '0;
    step();
    step();
    chk("rst_ack", 32'(fire_ack), 32'h0);
    chk("rst_busy", 32'(slot_busy), 32'h0);
    chk("rst_hit", 32'(hit_valid), 32'h0);
    reset = 1'b0;

    // Single arrow: target 3, two ticks, damage 5.
    set_tower(0, 3, 2, 5);
    step();
    chk("d1_ack", 32'(fire_ack), 32'h1);
    chk("d1_busy", 32'(slot_busy), 32'h1);
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();
    frame_tick = 1'b1; step();
    chk("d1_hit_early", 32'(hit_valid), 32'h0);
    frame_tick = 1'b0; step();
    chk("d1_hit", 32'(hit_valid), 32'h1);
    chk("d1_tgt", 32'(hit_target), 32'h3);
    chk("d1_dmg", 32'(hit_damage), 32'h5);

    // Four towers at once with only two slots.
    do_reset();
    set_tower(0, 1, 1, 1); set_tower(1, 2, 3, 2);
    set_tower(2, 3, 3, 3); set_tower(3, 4, 3, 4);
    step(); chk("d2_ack0", 32'(fire_ack), 32'h1);
    step(); chk("d2_ack1", 32'(fire_ack), 32'h2);
    step(); chk("d2_full", 32'(fire_ack), 32'h0);
    step();
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();
    chk("d2_hit", 32'(hit_valid), 32'h1);
    chk("d2_hit_tgt", 32'(hit_target), 32'h1);
    step(); chk("d2_ack2", 32'(fire_ack), 32'h4);
    step(); chk("d2_wait3", 32'(fire_ack), 32'h0);

    // Two arrows landing on the same tick are reported one per cycle.
    do_reset();
    set_tower(0, 5, 1, 7); set_tower(1, 6, 1, 8);
    step(); step();
    frame_tick = 1'b1; step();
    chk("d3_both_busy", 32'(slot_busy), 32'h3);
    chk("d3_no_hit", 32'(hit_valid), 32'h0);
    frame_tick = 1'b0; step();
    chk("d3_hit0", 32'(hit_target), 32'h5);
    step();
    chk("d3_hit1_v", 32'(hit_valid), 32'h1);
    chk("d3_hit1", 32'(hit_target), 32'h6);
    chk("d3_hit1_d", 32'(hit_damage), 32'h8);
    step();
    chk("d3_done", 32'(hit_valid), 32'h0);

    // No target or dead tower: never granted.
    do_reset();
    set_tower(0, 0, 2, 3); set_tower(1, 2, 2, 3);
    tower_alive = 4'b1101;
    for (int k = 0; k < 8; k++) begin
      frame_tick = 1'($urandom_range(0, 1));
      step();
      chk("d4_ack", 32'(fire_ack), 32'h0);
      chk("d4_busy", 32'(slot_busy), 32'h0);
    end
    tower_alive = '1;

    // Zero flight time behaves as one tick.
    do_reset();
    set_tower(2, 7, 0, 9);
    step(); chk("d5_ack", 32'(fire_ack), 32'h4);
    frame_tick = 1'b1; step();
    chk("d5_early", 32'(hit_valid), 32'h0);
    frame_tick = 1'b0; step();
    chk("d5_hit", 32'(hit_valid), 32'h1);
    chk("d5_tgt", 32'(hit_target), 32'h7);
    chk("d5_dmg", 32'(hit_damage), 32'h9);

    // Reset with both slots airborne drops the arrows.
    do_reset();
    set_tower(0, 1, 5, 1); set_tower(1, 2, 5, 2);
    step(); step();
    chk("d6_busy", 32'(slot_busy), 32'h3);
    reset = 1'b1; step();
    chk("d6_cleared", 32'(slot_busy), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      frame_tick = 1'b1;
      step();
      chk("d6_no_hit", 32'(hit_valid), 32'h0);
    end

`ifdef ARROW_SCHED_STATS_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_tower(k, k + 1, 1, 1);
      frame_tick = 1'b0; step();
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
    chk("stats3", 32'(shots_fired), 32'd3);
`endif

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NT; i++) begin
        tower_alive[i] = ($urandom_range(0, 19) != 0);
        if (!fire_req[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_tower(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 15)));
        end else if (tgt_of(i) == 0 && $urandom_range(0, 7) == 0) begin
          fire_req[i] = 1'b0;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
